// File: rtl/risc_pkg.sv
// Shared definitions for the pipelined RISC front end.
//   PC_W / INSTR_W : program counter and instruction widths
//   NOP_INSTR      : bubble word inserted into the IF/DOF register
//   HALT_OP        : opcode value that stops fetch
//   fetch_state_e  : fetch FSM encoding (2'd3 is illegal)
package risc_pkg;

    localparam int unsigned PC_W    = 16;
    localparam int unsigned INSTR_W = 32;

    // Opcode field position inside an instruction word
    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 25;

    localparam logic [INSTR_W-1:0]     NOP_INSTR = 32'h0000_0000;
    localparam logic [OP_MSB-OP_LSB:0] HALT_OP   = 7'h7F;

    typedef enum logic [1:0] {
        StBoot   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
    } fetch_state_e;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[OP_MSB:OP_LSB] == HALT_OP;
    endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC select for the fetch stage.
//   pc_i        : current program counter
//   br_target_i : redirect address
//   branch_i    : take the redirect (wins over hold_i)
//   hold_i      : keep the current PC
//   pc_inc_o    : pc_i + 1, modulo 2^PC_W
//   pc_next_o   : selected next PC
module pc_next
    import risc_pkg::*;
(
    input  logic [PC_W-1:0] pc_i,
    input  logic [PC_W-1:0] br_target_i,
    input  logic            branch_i,
    input  logic            hold_i,
    output logic [PC_W-1:0] pc_inc_o,
    output logic [PC_W-1:0] pc_next_o
);

    localparam logic [PC_W-1:0] PcOne = 1;

    // Plain PC_W-bit add: 16'hFFFF wraps to 16'h0000
    assign pc_inc_o = pc_i + PcOne;

    always_comb begin
        pc_next_o = pc_inc_o;
        if (branch_i) begin
            pc_next_o = br_target_i;
        end else if (hold_i) begin
            pc_next_o = pc_i;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and holds
// the IF/DOF pipeline register feeding the DOF operand muxes.
//   clk, rst   : clock and synchronous active-high reset
//   stall      : hold PC and IF/DOF register (RUN only)
//   br_taken   : redirect to br_target, squashing the fetched word
//   imem_addr  : instruction address (always the PC)
//   imem_data  : combinational instruction memory read data
//   IR, IM     : latched instruction and its low 15 bits
//   PC_1       : PC+1 of the instruction in IR
//   if_valid   : IR holds a real instruction
//   halted     : fetch is stopped on a halt opcode
module if_stage
    import risc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] IR,
    output logic [14:0]        IM,
    output logic [PC_W-1:0]    PC_1,
    output logic               if_valid,
    output logic               halted
);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    pc_inc;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [PC_W-1:0]    pc1_q, pc1_d;
    logic               valid_q, valid_d;
    logic               branch;
    logic               hold;

    pc_next u_pc_next (
        .pc_i        (pc_q),
        .br_target_i (br_target),
        .branch_i    (branch),
        .hold_i      (hold),
        .pc_inc_o    (pc_inc),
        .pc_next_o   (pc_d)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc1_d   = pc1_q;
        valid_d = valid_q;
        branch  = 1'b0;
        hold    = 1'b1;

        case (state_q)
            StBoot: begin
                // Single settling cycle; stall is deliberately not consulted
                ir_d    = NOP_INSTR;
                pc1_d   = '0;
                valid_d = 1'b0;
                state_d = StRun;
            end
            StRun: begin
                if (br_taken) begin
                    // Squash whatever is on imem_data this cycle
                    branch  = 1'b1;
                    hold    = 1'b0;
                    ir_d    = NOP_INSTR;
                    pc1_d   = '0;
                    valid_d = 1'b0;
                end else if (stall) begin
                    hold = 1'b1;
                end else if (is_halt(imem_data)) begin
                    // Latch the halt itself but park the PC on its address
                    ir_d    = imem_data;
                    pc1_d   = pc_inc;
                    valid_d = 1'b1;
                    state_d = StHalted;
                end else begin
                    hold    = 1'b0;
                    ir_d    = imem_data;
                    pc1_d   = pc_inc;
                    valid_d = 1'b1;
                end
            end
            StHalted: begin
                ir_d    = NOP_INSTR;
                pc1_d   = '0;
                valid_d = 1'b0;
                if (br_taken) begin
                    branch  = 1'b1;
                    hold    = 1'b0;
                    state_d = StRun;
                end
            end
            default: begin
                // Illegal encoding: recover through BOOT with a bubble
                ir_d    = NOP_INSTR;
                pc1_d   = '0;
                valid_d = 1'b0;
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            ir_q    <= NOP_INSTR;
            pc1_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            pc1_q   <= pc1_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr = pc_q;
    assign IR        = ir_q;
    assign IM        = ir_q[14:0];
    assign PC_1      = pc1_q;
    assign if_valid  = valid_q;
    assign halted    = (state_q == StHalted);

endmodule
